// File: rtl/mix_columns_if.sv
// mix_columns_if: ShiftRows-side input and AddRoundKey-side output handshakes of mix_columns
`timescale 1ns/1ps
interface mix_columns_if #(parameter int DATA_WIDTH = 128);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  last_round;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] data_out;
  modport slave (input in_valid, data_in, last_round, out_ready, output in_ready, out_valid, data_out);
  modport master (output in_valid, data_in, last_round, out_ready, input in_ready, out_valid, data_out);
endinterface

// File: rtl/mix_columns.sv
// mix_columns: AES MixColumns, one shared column datapath iterated over 4 cycles, bypassed in the final round
`timescale 1ns/1ps
module mix_columns #(parameter int DATA_WIDTH = 128) (
  input logic clk,
  input logic rst,
  mix_columns_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_next;
  logic [1:0] col;
  logic [DATA_WIDTH-1:0] st;
  logic [7:0] a0, a1, a2, a3;
  logic [31:0] col_out;
  logic accept;
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  assign {a3, a2, a1, a0} = st[{col, 5'd0} +: 32];
  assign col_out = {xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3),
                    a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                    a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                    xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3};
  // held low through the reset cycle so nothing is accepted while state is being cleared
  assign bus.in_ready = !rst && (state == IDLE || (state == DONE && bus.out_ready));
  assign accept = bus.in_valid && bus.in_ready;
  assign bus.out_valid = state == DONE;
  assign bus.data_out = st;
  always_comb begin
    state_next = IDLE;
    if (accept) state_next = bus.last_round ? DONE : BUSY;
    else if (state == BUSY) state_next = col == 2'd3 ? DONE : BUSY;
    else if (state == DONE) state_next = bus.out_ready ? IDLE : DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      col <= 2'd0;
      st <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        st <= bus.data_in;
        col <= 2'd0;
      end else if (state == BUSY) begin
        st[{col, 5'd0} +: 32] <= col_out;
        col <= col + 2'd1;
      end
    end
  end
endmodule

// File: tb/tb_mix_columns.sv
// tb_mix_columns: directed FIPS-197 latency, bypass, backpressure, reset-abort, back-to-back and random streaming checks
`timescale 1ns/1ps
module tb_mix_columns;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int failures = 0;
  localparam logic [127:0] FIPS_IN  = 128'h4c31262d_01010101_5c220af2_455313db;
  localparam logic [127:0] FIPS_OUT = 128'hf8bd7e4d_01010101_9d58dc9f_bca14d8e;
  logic [127:0] vec_in [3];
  logic [127:0] vec_exp [3];
  mix_columns_if #(.DATA_WIDTH(128)) bus ();
  mix_columns #(.DATA_WIDTH(128)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction
  function automatic logic [127:0] model(input logic [127:0] d, input bit last);
    logic [127:0] r = d;
    logic [7:0] coef [4] = '{8'h02, 8'h03, 8'h01, 8'h01};
    if (last) return d;
    for (int c = 0; c < 4; c++)
      for (int row = 0; row < 4; row++) begin
        logic [7:0] b = 8'h00;
        for (int k = 0; k < 4; k++) b ^= gmul(coef[(k - row + 4) % 4], d[8*(4*c+k) +: 8]);
        r[8*(4*c+row) +: 8] = b;
      end
    return r;
  endfunction
  task automatic single(input string tag, input logic [127:0] d, input bit last, input int lat,
                        input logic [127:0] exp, input int hold, input bit pulse);
    logic [127:0] first;
    @(negedge clk);
    bus.data_in = d; bus.last_round = last; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    #1 chk({tag, "_in_ready"}, bus.in_ready, 1'b1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int k = 1; k <= lat; k++) begin
      if (pulse && k == 1) begin bus.in_valid = 1'b1; bus.data_in = ~d; bus.last_round = 1'b1; end
      if (pulse && k == 2) bus.in_valid = 1'b0;
      @(negedge clk);
      chk({tag, "_latency"}, bus.out_valid, k == lat);
    end
    chk({tag, "_data"}, bus.data_out, exp);
    first = bus.data_out;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, "_hold_valid"}, bus.out_valid, 1'b1);
      chk({tag, "_hold_data"}, bus.data_out, first);
      chk({tag, "_hold_in_ready"}, bus.in_ready, 1'b0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk({tag, "_drained"}, bus.out_valid, 1'b0);
  endtask
  task automatic stream(input string tag, input int n, input bit rnd);
    logic [127:0] q [$];
    logic [127:0] w = '0;
    bit lr = 1'b0;
    bit acc = 1'b0;
    int sent = 0, got = 0, cyc = 0, prev = -1;
    while (got < n && cyc < n * 20 + 50) begin
      @(negedge clk);
      if (acc) bus.in_valid = 1'b0;
      acc = 1'b0;
      if (!bus.in_valid && sent < n) begin
        w = rnd ? {$urandom, $urandom, $urandom, $urandom} : vec_in[sent];
        lr = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.data_in = w; bus.last_round = lr; bus.in_valid = 1'b1;
      end
      bus.out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      #1;
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) chk({tag, "_extra"}, 1'b1, 1'b0);
        else chk({tag, "_data"}, bus.data_out, q.pop_front());
        if (!rnd && prev >= 0) chk({tag, "_interval"}, 128'(cyc - prev), 128'd5);
        prev = cyc;
        got++;
      end
      if (bus.in_valid && bus.in_ready) begin
        q.push_back(rnd ? model(w, lr) : vec_exp[sent]);
        sent++;
        acc = 1'b1;
      end
      @(posedge clk);
      cyc++;
    end
    @(negedge clk);
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    chk({tag, "_count"}, 128'(got), 128'(n));
    chk({tag, "_leftover"}, 128'(q.size()), 128'd0);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
  initial begin
    vec_in[0] = FIPS_IN;
    vec_exp[0] = FIPS_OUT;
    vec_in[1] = 128'hd5d4d4d4_c6c6c6c6_01010101_455313db;
    vec_exp[1] = 128'hd6d7d5d5_c6c6c6c6_01010101_bca14d8e;
    vec_in[2] = 128'h4c31262d_5c220af2_d5d4d4d4_00000000;
    vec_exp[2] = 128'hf8bd7e4d_9d58dc9f_d6d7d5d5_00000000;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.data_in = '0; bus.last_round = 1'b0; bus.out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_out_valid", bus.out_valid, 1'b0);
    chk("reset_data_out", bus.data_out, '0);
    chk("reset_in_ready", bus.in_ready, 1'b0);
    rst = 1'b0;
    #1 chk("post_reset_in_ready", bus.in_ready, 1'b1);
    single("fips", FIPS_IN, 1'b0, 4, FIPS_OUT, 10, 1'b1);
    single("bypass", FIPS_IN, 1'b1, 1, FIPS_IN, 2, 1'b0);
    @(negedge clk);
    bus.data_in = vec_in[1]; bus.last_round = 1'b0; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_out_valid", bus.out_valid, 1'b0);
    chk("abort_data_out", bus.data_out, '0);
    chk("abort_in_ready", bus.in_ready, 1'b0);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("abort_never_presented", bus.out_valid, 1'b0);
    end
    bus.out_ready = 1'b0;
    single("after_abort", FIPS_IN, 1'b0, 4, FIPS_OUT, 0, 1'b0);
    stream("b2b", 3, 1'b0);
    stream("rand", 1000, 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
